rf_access_sequencer: RTL and testbench

- Sits directly upstream of the 32x32 dual-read register file. It is the only block that drives the file's READ, WRITE, address and write-data inputs.
- Turns operand-fetch requests from decode into single READ cycles. Captures DATA_R1/DATA_R2 into holding registers.
- Buffers write-back requests in a small FIFO and drains them as WRITE cycles.
- Guarantees READ and WRITE are never both 1 in the same cycle, and that a read never returns stale data for a register with a write still pending.

---
 rtl/rf_access_sequencer.sv | 154 +++++++++++++++
 tb/tb_rf_access_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_sequencer.sv
// Register-file access sequencer: arbitrates operand reads against a small
// write-back FIFO so that READ and WRITE never coincide and reads never see stale data.
module rf_access_sequencer #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int WB_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              rd_valid,
   output logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] op2,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_full,
   output logic              wb_overflow,
   output logic              RF_READ,
   output logic              RF_WRITE,
   output logic [ADDR_W-1:0] RF_ADDR_R1,
   output logic [ADDR_W-1:0] RF_ADDR_R2,
   output logic [ADDR_W-1:0] RF_ADDR_W,
   output logic [DATA_W-1:0] RF_DATA_W,
   input  logic [DATA_W-1:0] RF_DATA_R1,
   input  logic [DATA_W-1:0] RF_DATA_R2
);

   localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int unsigned DEPTH_U = WB_DEPTH;

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [WB_DEPTH-1:0] valid_q, valid_d;
   logic [ADDR_W-1:0]   fifo_addr_q [WB_DEPTH];
   logic [ADDR_W-1:0]   fifo_addr_d [WB_DEPTH];
   logic [DATA_W-1:0]   fifo_data_q [WB_DEPTH];
   logic [DATA_W-1:0]   fifo_data_d [WB_DEPTH];
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic                overflow_q, overflow_d;

   logic                push, pop, hazard, pending_rd, full_eval;
   logic [CNT_W-1:0]    count_eval;
   logic [WB_DEPTH-1:0] valid_eval;

   assign wb_full     = (count_q == CNT_W'(WB_DEPTH));
   assign wb_overflow = overflow_q;
   assign rd_valid    = rd_valid_q;
   assign op1         = op1_q;
   assign op2         = op2_q;
   assign RF_READ     = (state_q == RD);
   assign RF_WRITE    = (state_q == WR);
   assign RF_ADDR_R1  = rd_addr1;
   assign RF_ADDR_R2  = rd_addr2;
   assign RF_ADDR_W   = fifo_addr_q[rd_ptr_q];
   assign RF_DATA_W   = fifo_data_q[rd_ptr_q];

   // FIFO bookkeeping: push, pop, overflow flag
   always_comb begin
      push        = wb_req && !wb_full && (wb_addr != '0);
      pop         = (state_q == WR);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      valid_d     = valid_q;
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      overflow_d  = overflow_q | (wb_req && wb_full);
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         valid_d[wr_ptr_q]     = 1'b1;
         fifo_addr_d[wr_ptr_q] = wb_addr;
         fifo_data_d[wr_ptr_q] = wb_data;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Arbitration sees the queue with this cycle's WR entry already retired,
   // otherwise a single-entry queue would be written twice.
   always_comb begin
      count_eval = count_q - CNT_W'(pop);
      full_eval  = (count_eval == CNT_W'(WB_DEPTH));
      valid_eval = valid_q;
      if (pop) valid_eval[rd_ptr_q] = 1'b0;
      hazard = 1'b0;
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
         if (valid_eval[PTR_W'(i)] &&
             ((fifo_addr_q[PTR_W'(i)] == rd_addr1) || (fifo_addr_q[PTR_W'(i)] == rd_addr2)))
            hazard = 1'b1;
      end
      hazard     = hazard && rd_req;
      pending_rd = rd_req && (state_q != RD) && !rd_valid_q;

      if ((count_eval != '0) && (full_eval || hazard || !pending_rd))
         state_d = WR;
      else if (pending_rd)
         state_d = RD;
      else
         state_d = IDLE;
   end

   always_comb begin
      rd_valid_d = (state_q == RD);
      op1_d      = op1_q;
      op2_d      = op2_q;
      if (state_q == RD) begin
         op1_d = RF_DATA_R1;
         op2_d = RF_DATA_R2;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         rd_valid_q <= 1'b0;
         op1_q      <= '0;
         op2_q      <= '0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH_U; i++) begin
            fifo_addr_q[PTR_W'(i)] <= '0;
            fifo_data_q[PTR_W'(i)] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         rd_valid_q  <= rd_valid_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         overflow_q  <= overflow_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
      end
   end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed bench for rf_access_sequencer with a behavioural 32x32 register file
// attached to its RF_* ports; every check is an immediate assertion.
module tb_rf_access_sequencer;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int WB_DEPTH = 4;

   logic              CLK = 1'b0;
   logic              RST;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2;
   logic              rd_valid;
   logic [DATA_W-1:0] op1, op2;
   logic              wb_req;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wb_full, wb_overflow;
   logic              RF_READ, RF_WRITE;
   logic [ADDR_W-1:0] RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
   logic [DATA_W-1:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;

   logic [DATA_W-1:0] rf [32];
   int                wlog[$];
   int                n_cmp = 0;
   int                n_mis = 0;
   int                overlap = 0;
   int                base;
   logic              got;

   rf_access_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_valid(rd_valid), .op1(op1), .op2(op2),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_full(wb_full), .wb_overflow(wb_overflow),
      .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
      .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
      .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
      .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
   );

   always #5 CLK = ~CLK;

   assign RF_DATA_R1 = rf[RF_ADDR_R1];
   assign RF_DATA_R2 = rf[RF_ADDR_R2];

   always @(posedge CLK) begin
      if (RF_WRITE === 1'b1) begin
         rf[RF_ADDR_W] <= RF_DATA_W;
         wlog.push_back(int'(RF_ADDR_W));
      end
   end

   always @(negedge CLK)
      if (RF_READ === 1'b1 && RF_WRITE === 1'b1) overlap++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[3] = 32'h11; rf[7] = 32'h22; rf[20] = 32'hA0; rf[21] = 32'hA1;
      RST = 1'b1; rd_req = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
      wb_req = 1'b0; wb_addr = '0; wb_data = '0;
      step(); step();
      check("rst_read", 32'(RF_READ), 32'd0);
      check("rst_write", 32'(RF_WRITE), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_op1", op1, 32'd0);
      check("rst_full", 32'(wb_full), 32'd0);
      check("rst_ovf", 32'(wb_overflow), 32'd0);
      RST = 1'b0;
      step();

      // plain read of r3/r7
      rd_req = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd7;
      #1;
      check("t1_addr_r1", 32'(RF_ADDR_R1), 32'd3);
      check("t1_addr_r2", 32'(RF_ADDR_R2), 32'd7);
      step();
      check("t1_rd_state", 32'(RF_READ), 32'd1);
      check("t1_rd_nowrite", 32'(RF_WRITE), 32'd0);
      check("t1_rv_early", 32'(rd_valid), 32'd0);
      step();
      check("t1_rv", 32'(rd_valid), 32'd1);
      check("t1_op1", op1, 32'h11);
      check("t1_op2", op2, 32'h22);
      check("t1_read_off", 32'(RF_READ), 32'd0);
      rd_req = 1'b0;
      step();
      check("t1_rv_pulse", 32'(rd_valid), 32'd0);
      check("t1_op1_hold", op1, 32'h11);
      check("t1_no_writes", 32'(wlog.size()), 32'd0);

      // hazard: queued write to r5 must land before the read
      wb_req = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      step();
      wb_req = 1'b0; rd_req = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd7;
      check("t2_idle_nowrite", 32'(RF_WRITE), 32'd0);
      step();
      check("t2_wr_first", 32'(RF_WRITE), 32'd1);
      check("t2_wr_noread", 32'(RF_READ), 32'd0);
      check("t2_wr_addr", 32'(RF_ADDR_W), 32'd5);
      check("t2_wr_data", RF_DATA_W, 32'hDEADBEEF);
      step();
      check("t2_rd_after", 32'(RF_READ), 32'd1);
      check("t2_rd_nowrite", 32'(RF_WRITE), 32'd0);
      step();
      check("t2_rv", 32'(rd_valid), 32'd1);
      check("t2_op1", op1, 32'hDEADBEEF);
      check("t2_op2", op2, 32'h22);
      rd_req = 1'b0;
      step(); step();

      // fill the FIFO while a read stream competes, then overflow
      base = wlog.size();
      rd_req = 1'b1; rd_addr1 = 5'd20; rd_addr2 = 5'd21;
      for (int k = 0; k < 8; k++) begin
         wb_req = 1'b1; wb_addr = 5'(k + 1); wb_data = 32'h100 + 32'(k + 1);
         if (k == 7) begin
            check("t3_notfull_c7", 32'(wb_full), 32'd0);
            check("t3_rd_c7", 32'(RF_READ), 32'd1);
         end
         step();
      end
      check("t3_full", 32'(wb_full), 32'd1);
      check("t3_rv_c8", 32'(rd_valid), 32'd1);
      check("t3_op1_c8", op1, 32'hA0);
      check("t3_wr_c8", 32'(RF_WRITE), 32'd1);
      check("t3_head_c8", 32'(RF_ADDR_W), 32'd5);
      rd_req = 1'b0; wb_addr = 5'd9; wb_data = 32'h109;
      step();
      wb_req = 1'b0;
      check("t3_overflow", 32'(wb_overflow), 32'd1);
      check("t3_full_clear", 32'(wb_full), 32'd0);
      check("t3_head_c9", 32'(RF_ADDR_W), 32'd6);
      step(); step(); step();
      check("t3_drained", 32'(RF_WRITE), 32'd0);
      check("t3_nwrites", 32'(wlog.size() - base), 32'd8);
      for (int k = 0; k < 8; k++)
         if (base + k < wlog.size()) check($sformatf("t3_order%0d", k), 32'(wlog[base + k]), 32'(k + 1));
      check("t3_r8", rf[8], 32'h108);
      check("t3_r9_dropped", rf[9], 32'd0);
      check("t3_ovf_sticky", 32'(wb_overflow), 32'd1);

      RST = 1'b1;
      step();
      check("t3_rst_ovf", 32'(wb_overflow), 32'd0);
      RST = 1'b0;

      // write to r0 is discarded
      base = wlog.size();
      wb_req = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      step();
      wb_req = 1'b0;
      check("t4_full", 32'(wb_full), 32'd0);
      check("t4_nowrite1", 32'(RF_WRITE), 32'd0);
      step();
      check("t4_nowrite2", 32'(RF_WRITE), 32'd0);
      check("t4_noovf", 32'(wb_overflow), 32'd0);
      step();
      check("t4_nlog", 32'(wlog.size() - base), 32'd0);

      // continuous writes to r9 with an unrelated read pending
      rd_req = 1'b1; rd_addr1 = 5'd2; rd_addr2 = 5'd4;
      got = 1'b0;
      for (int i = 0; i < WB_DEPTH + 2 && !got; i++) begin
         wb_req = !wb_full; wb_addr = 5'd9; wb_data = 32'h900 + 32'(i);
         step();
         if (rd_valid) got = 1'b1;
      end
      wb_req = 1'b0; rd_req = 1'b0;
      check("t5_rv_bound", 32'(got), 32'd1);
      check("t5_op1", op1, 32'h102);
      check("t5_op2", op2, 32'h104);
      for (int i = 0; i < 6; i++) step();
      check("t5_r9", rf[9], 32'h901);
      check("t5_idle", 32'(RF_WRITE), 32'd0);

      // reset in the middle of a read
      base = wlog.size();
      rd_req = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd7;
      wb_req = 1'b1; wb_addr = 5'd13; wb_data = 32'hD13;
      step();
      check("t6_in_rd", 32'(RF_READ), 32'd1);
      RST = 1'b1; rd_req = 1'b0; wb_req = 1'b0;
      step();
      check("t6_rv", 32'(rd_valid), 32'd0);
      check("t6_op1", op1, 32'd0);
      check("t6_op2", op2, 32'd0);
      check("t6_read", 32'(RF_READ), 32'd0);
      check("t6_write", 32'(RF_WRITE), 32'd0);
      check("t6_ovf", 32'(wb_overflow), 32'd0);
      RST = 1'b0;
      step();
      check("t6_rv_after", 32'(rd_valid), 32'd0);
      step(); step();
      check("t6_fifo_empty", 32'(wlog.size() - base), 32'd0);
      check("t6_r13", rf[13], 32'd0);

      check("no_rw_overlap", 32'(overlap), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
